// File: rtl/inst_align_expand.sv
// Halfword-aligning instruction buffer between the I-memory port and decode.
// Define RVC_EXPAND_EN to expand compressed instructions into their RV32I equivalents.
module inst_align_expand #(
  parameter logic [31:0] RESET_PC = 32'h00000060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fw_valid,
  output logic        fw_ready,
  input  logic [31:0] fw_data,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        is_compr,
  output logic        illegal
);
  localparam logic [31:0] NOP = 32'h00000013;

  logic [15:0] hw_q [4];
  logic [15:0] hw_d [4];
  logic [2:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic        skip_q, skip_d;

  logic        head_is32, head_avail, push, pop;
  logic [2:0]  pop_n, base;
  logic [63:0] shifted;
  logic [31:0] c_ir;
  logic        c_ill;

  assign fw_ready   = (count_q <= 3'd2) || flush;
  assign head_is32  = (hw_q[0][1:0] == 2'b11);
  assign head_avail = head_is32 ? (count_q >= 3'd2) : (count_q >= 3'd1);
  assign ir_valid   = head_avail && !flush;
  assign push       = fw_valid && fw_ready && !flush;
  assign pop        = ir_valid && ir_ready;
  assign pc         = head_pc_q;

  // Pop first (shift the FIFO down), then append the incoming halfwords at the new tail.
  always_comb begin
    pop_n = 3'd0;
    if (pop) pop_n = head_is32 ? 3'd2 : 3'd1;
    base    = count_q - pop_n;
    shifted = {hw_q[3], hw_q[2], hw_q[1], hw_q[0]} >> {pop_n, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      hw_d[i] = shifted[16*i +: 16];
      if (push) begin
        if (skip_q) begin
          if (3'(i) == base) hw_d[i] = fw_data[31:16];
        end else begin
          if (3'(i) == base)        hw_d[i] = fw_data[15:0];
          if (3'(i) == base + 3'd1) hw_d[i] = fw_data[31:16];
        end
      end
    end
    count_d = base;
    if (push) count_d = base + (skip_q ? 3'd1 : 3'd2);
    skip_d    = push ? 1'b0 : skip_q;
    head_pc_d = head_pc_q;
    if (pop) head_pc_d = head_pc_q + (head_is32 ? 32'd4 : 32'd2);
    if (flush) begin
      count_d   = 3'd0;
      head_pc_d = flush_pc & ~32'd1;
      skip_d    = flush_pc[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hw_q[i] <= '0;
      count_q   <= 3'd0;
      head_pc_q <= RESET_PC;
      skip_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) hw_q[i] <= hw_d[i];
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
      skip_q    <= skip_d;
    end
  end

`ifdef RVC_EXPAND_EN
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm6;
  logic [20:0] joff;
  logic [12:0] boff;
  logic [31:0] enc;
  logic [2:0]  alu_f3;
  logic        ill;

  always_comb begin
    c    = hw_q[0];
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[4:2]};
    rs1p = {2'b01, c[9:7]};
    imm6 = {{6{c[12]}}, c[12], c[6:2]};
    joff = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    boff = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    enc  = NOP;
    ill  = 1'b0;
    alu_f3 = 3'b000;
    case ({c[1:0], c[15:13]})
      5'b00_000: if (c[12:5] == 8'd0) ill = 1'b1;
                 else enc = enc_i({2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00}, 5'd2, 3'b000, rdp, OP_IMM);
      5'b00_010: enc = enc_i({5'b0, c[5], c[12:10], c[6], 2'b00}, rs1p, 3'b010, rdp, OP_LD);
      5'b00_110: enc = enc_s({5'b0, c[5], c[12:10], c[6], 2'b00}, rdp, rs1p);
      5'b01_000: enc = enc_i(imm6, rd, 3'b000, rd, OP_IMM);
      5'b01_001: enc = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd1, 7'b1101111};
      5'b01_010: enc = enc_i(imm6, 5'd0, 3'b000, rd, OP_IMM);
      5'b01_011: begin
        if (rd == 5'd2)
          enc = enc_i({{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000}, 5'd2, 3'b000, 5'd2, OP_IMM);
        else if ({c[12], c[6:2]} == 6'd0) ill = 1'b1;
        else enc = {{15{c[12]}}, c[6:2], rd, 7'b0110111};
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00:   if (c[12]) ill = 1'b1;
                   else enc = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
          2'b01:   if (c[12]) ill = 1'b1;
                   else enc = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OP_IMM};
          2'b10:   enc = enc_i(imm6, rs1p, 3'b111, rs1p, OP_IMM);
          default: begin
            case (c[6:5])
              2'b00:   alu_f3 = 3'b000;
              2'b01:   alu_f3 = 3'b100;
              2'b10:   alu_f3 = 3'b110;
              default: alu_f3 = 3'b111;
            endcase
            if (c[12]) ill = 1'b1;
            else enc = enc_r((c[6:5] == 2'b00) ? 7'b0100000 : 7'b0000000, rdp, rs1p, alu_f3, rs1p);
          end
        endcase
      end
      5'b01_101: enc = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd0, 7'b1101111};
      5'b01_110, 5'b01_111:
        enc = {boff[12], boff[10:5], 5'd0, rs1p, {2'b00, c[13]}, boff[4:1], boff[11], 7'b1100011};
      5'b10_000: if (c[12]) ill = 1'b1;
                 else enc = {7'b0000000, c[6:2], rd, 3'b001, rd, OP_IMM};
      5'b10_010: if (rd == 5'd0) ill = 1'b1;
                 else enc = enc_i({4'b0, c[3:2], c[12], c[6:4], 2'b00}, 5'd2, 3'b010, rd, OP_LD);
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 != 5'd0)     enc = enc_r(7'b0, rs2, 5'd0, 3'b000, rd);
          else if (rd == 5'd0) ill = 1'b1;
          else                 enc = enc_i(12'd0, rd, 3'b000, 5'd0, 7'b1100111);
        end else begin
          if (rs2 != 5'd0)     enc = enc_r(7'b0, rs2, rd, 3'b000, rd);
          else if (rd == 5'd0) enc = 32'h00100073;
          else                 enc = enc_i(12'd0, rd, 3'b000, 5'd1, 7'b1100111);
        end
      end
      5'b10_110: enc = enc_s({4'b0, c[8:7], c[12:9], 2'b00}, rs2, 5'd2);
      default:   ill = 1'b1;  // FP, RV64-only and reserved slots
    endcase
    c_ill = ill;
    c_ir  = ill ? NOP : enc;
  end
`else
  assign c_ir  = {16'h0000, hw_q[0]};
  assign c_ill = 1'b1;
`endif

  always_comb begin
    ir       = NOP;
    is_compr = 1'b0;
    illegal  = 1'b0;
    if (ir_valid) begin
      if (head_is32) begin
        ir = {hw_q[1], hw_q[0]};
      end else begin
        ir       = c_ir;
        is_compr = 1'b1;
        illegal  = c_ill;
      end
    end
  end
endmodule
